// File: rtl/srt_div_pkg.sv
// Shared types, constants and the IEEE special-case resolver for the FP32 radix-4 SRT divider.
//   state_e       : sequencer states (idle, core load, iterate, result hold)
//   fp32_class_e  : operand classes produced by fp32_classify
//   fp32_special  : maps the two operand classes and the result sign to a bypass result
package srt_div_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StIter, StDone} state_e;

  typedef enum logic [2:0] {ClsZero, ClsSubnorm, ClsNorm, ClsInf, ClsNan} fp32_class_e;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam int unsigned SRT4_ITERS   = 13;

  typedef struct packed {
    logic        hit;
    logic [31:0] value;
  } special_t;

  // Branch order is the resolution priority; later branches rely on earlier ones being excluded.
  function automatic special_t fp32_special(input fp32_class_e a, input fp32_class_e b,
                                            input logic s);
    special_t r;
    r.hit   = 1'b1;
    r.value = FP32_QNAN;
    if (a == ClsNan || b == ClsNan) begin
      r.value = FP32_QNAN;
    end else if ((a == ClsZero && b == ClsZero) || (a == ClsInf && b == ClsInf)) begin
      r.value = FP32_QNAN;
    end else if (b == ClsZero || a == ClsInf) begin
      r.value = {s, FP32_EXP_MAX, 23'b0};
    end else if (a == ClsZero || b == ClsInf) begin
      r.value = {s, 31'b0};
    end else begin
      r.hit   = 1'b0;
      r.value = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 operand classifier.
//   op  : FP32 operand
//   cls : zero / subnormal / normal / infinity / NaN
module fp32_classify
  import srt_div_pkg::*;
(
  input  logic [31:0]  op,
  output fp32_class_e  cls
);

  logic [7:0]  exp_f;
  logic [22:0] man_f;

  assign exp_f = op[30:23];
  assign man_f = op[22:0];

  always_comb begin
    cls = ClsNorm;
    if (exp_f == 8'h00) begin
      cls = (man_f == 23'b0) ? ClsZero : ClsSubnorm;
    end else if (exp_f == FP32_EXP_MAX) begin
      cls = (man_f == 23'b0) ? ClsInf : ClsNan;
    end
  end

endmodule

// File: rtl/srt_div_ctrl.sv
// Sequencer for the FP32 radix-4 SRT divider datapath.
//   in_valid/in_ready, dividend, divisor : operand handshake, accepted only in idle
//   flush                                : synchronous abort, returns to idle
//   core_load, core_en                   : core latch pulse and per-iteration enable
//   core_dividend, core_divisor          : registered operands to the core
//   core_quotient                        : post-processed core result
//   out_valid/out_ready, quotient        : result handshake, quotient held while valid
//   out_special                          : result bypassed the core
//   busy                                 : any state other than idle
// ITERS must be below 2**CNT_W so the counter never wraps inside an operation.
module srt_div_ctrl
  import srt_div_pkg::*;
#(
  parameter int unsigned ITERS = SRT4_ITERS,
  parameter int unsigned CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        core_load,
  output logic        core_en,
  output logic [31:0] core_dividend,
  output logic [31:0] core_divisor,
  input  logic [31:0] core_quotient,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic        out_special,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(ITERS - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               core_load_q, core_en_q, out_valid_q, out_special_q;
  logic [31:0]        quotient_q, dividend_q, divisor_q;

  fp32_class_e        a_cls, b_cls;
  special_t           spec;
  logic               accept;

  // Incoming operands are classified so the bypass decision lands on the acceptance edge.
  fp32_classify u_cls_a (
    .op  (dividend),
    .cls (a_cls)
  );

  fp32_classify u_cls_b (
    .op  (divisor),
    .cls (b_cls)
  );

  assign spec   = fp32_special(a_cls, b_cls, dividend[31] ^ divisor[31]);
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      core_load_q   <= 1'b0;
      core_en_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_special_q <= 1'b0;
      quotient_q    <= '0;
      dividend_q    <= '0;
      divisor_q     <= '0;
    end else if (flush && state_q != StIdle) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      core_load_q <= 1'b0;
      core_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            dividend_q <= dividend;
            divisor_q  <= divisor;
            if (spec.hit) begin
              quotient_q    <= spec.value;
              out_special_q <= 1'b1;
              out_valid_q   <= 1'b1;
              state_q       <= StDone;
            end else begin
              out_special_q <= 1'b0;
              core_load_q   <= 1'b1;
              state_q       <= StLoad;
            end
          end
        end
        StLoad: begin
          core_load_q <= 1'b0;
          core_en_q   <= 1'b1;
          cnt_q       <= '0;
          state_q     <= StIter;
        end
        StIter: begin
          // core_en stays high through the cycle where the last iteration runs.
          if (cnt_q == LastCnt) begin
            core_en_q   <= 1'b0;
            quotient_q  <= core_quotient;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Flush in idle blocks acceptance in the same cycle.
  assign in_ready      = (state_q == StIdle) && !flush;
  assign busy          = (state_q != StIdle);
  assign core_load     = core_load_q;
  assign core_en       = core_en_q;
  assign out_valid     = out_valid_q;
  assign out_special   = out_special_q;
  assign quotient      = quotient_q;
  assign core_dividend = dividend_q;
  assign core_divisor  = divisor_q;

endmodule

// File: tb/tb_srt_div_ctrl.sv
// Directed self-checking bench for srt_div_ctrl. Cycle 0 is the acceptance cycle; cycle n is the
// clock period following the n-th rising edge after acceptance.
module tb_srt_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        core_load;
  logic        core_en;
  logic [31:0] core_dividend;
  logic [31:0] core_divisor;
  logic [31:0] core_quotient = 32'h40400000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic        out_special;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  srt_div_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .dividend      (dividend),
    .divisor       (divisor),
    .flush         (flush),
    .core_load     (core_load),
    .core_en       (core_en),
    .core_dividend (core_dividend),
    .core_divisor  (core_divisor),
    .core_quotient (core_quotient),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .quotient      (quotient),
    .out_special   (out_special),
    .busy          (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check_eq("in_ready_idle", {31'b0, in_ready}, 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Returns at the falling edge of the first cycle with out_valid high (vcyc=0 if it never rose).
  task automatic wait_done(output int vcyc, output int first_load, output int first_en,
                           output int en_cnt);
    vcyc = 0; first_load = 0; first_en = 0; en_cnt = 0;
    for (int c = 1; c <= 40 && vcyc == 0; c++) begin
      @(negedge clk);
      if (core_load && first_load == 0) first_load = c;
      if (core_en) begin
        en_cnt++;
        if (first_en == 0) first_en = c;
      end
      if (out_valid) vcyc = c;
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
    check_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic run_normal(input string tag);
    int vc, fl, fe, ec;
    start_op(32'h40C00000, 32'h40000000);
    wait_done(vc, fl, fe, ec);
    check_eq({tag, "_valid_cyc"}, vc, 32'd15);
    check_eq({tag, "_load_cyc"}, fl, 32'd1);
    check_eq({tag, "_en_first"}, fe, 32'd2);
    check_eq({tag, "_en_count"}, ec, 32'd13);
    check_eq({tag, "_quotient"}, quotient, 32'h40400000);
    check_eq({tag, "_special"}, {31'b0, out_special}, 32'd0);
    check_eq({tag, "_core_dvd"}, core_dividend, 32'h40C00000);
    check_eq({tag, "_core_dvs"}, core_divisor, 32'h40000000);
    release_result(tag);
  endtask

  task automatic run_special(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expq);
    int vc, fl, fe, ec;
    start_op(a, b);
    wait_done(vc, fl, fe, ec);
    check_eq({tag, "_valid_cyc"}, vc, 32'd1);
    check_eq({tag, "_no_load"}, fl, 32'd0);
    check_eq({tag, "_quotient"}, quotient, expq);
    check_eq({tag, "_special"}, {31'b0, out_special}, 32'd1);
    release_result(tag);
  endtask

  initial begin
    int vc, fl, fe, ec, ovc;

    // Reset values while rst is held low.
    #12;
    check_eq("rst_core_load", {31'b0, core_load}, 32'd0);
    check_eq("rst_core_en", {31'b0, core_en}, 32'd0);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out_special", {31'b0, out_special}, 32'd0);
    check_eq("rst_quotient", quotient, 32'd0);
    check_eq("rst_core_dvd", core_dividend, 32'd0);
    check_eq("rst_core_dvs", core_divisor, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);

    run_normal("norm");

    run_special("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000);
    run_special("zero_zero", 32'h00000000, 32'h00000000, 32'h7FC00000);
    run_special("nan_one", 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    run_special("ninf_inf", 32'hFF800000, 32'h7F800000, 32'h7FC00000);
    run_special("nzero_five", 32'h80000000, 32'h40A00000, 32'h80000000);

    // Output back-pressure with a competing operand offer.
    start_op(32'h40C00000, 32'h40000000);
    wait_done(vc, fl, fe, ec);
    check_eq("stall_valid_cyc", vc, 32'd15);
    dividend = 32'h3F800000;
    divisor  = 32'h3F800000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_quotient", quotient, 32'h40400000);
      check_eq("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check_eq("stall_out_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    release_result("stall");
    check_eq("stall_ignored_dvd", core_dividend, 32'h40C00000);

    // Flush in idle outranks an offered operand.
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    dividend = 32'h3F800000;
    divisor  = 32'h00000000;
    #1 check_eq("idle_flush_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    check_eq("idle_flush_busy", {31'b0, busy}, 32'd0);
    check_eq("idle_flush_valid", {31'b0, out_valid}, 32'd0);

    // Flush on the fifth core_en cycle.
    start_op(32'h40C00000, 32'h40000000);
    ec = 0;
    for (int c = 1; c <= 40 && ec < 5; c++) begin
      @(negedge clk);
      if (core_en) ec++;
    end
    check_eq("flush_reached_en5", ec, 32'd5);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_eq("flush_core_en", {31'b0, core_en}, 32'd0);
    check_eq("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("flush_busy", {31'b0, busy}, 32'd0);
    ovc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) ovc++;
    end
    check_eq("flush_no_result", ovc, 32'd0);
    run_normal("after_flush");

    // Asynchronous reset in the middle of iteration.
    start_op(32'h40C00000, 32'h40000000);
    repeat (6) @(negedge clk);
    check_eq("mid_rst_in_iter", {31'b0, core_en}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_core_en", {31'b0, core_en}, 32'd0);
    check_eq("mid_rst_core_load", {31'b0, core_load}, 32'd0);
    check_eq("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("mid_rst_busy", {31'b0, busy}, 32'd0);
    check_eq("mid_rst_core_dvd", core_dividend, 32'd0);
    check_eq("mid_rst_quotient", quotient, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_normal("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/srt_div_ctrl.md
Name: srt_div_ctrl

Overview:
Sequencer for the FP32 radix-4 SRT divider datapath (normalizer + digit-recurrence core + post-processing).
- Accepts operand pairs through a valid/ready handshake and registers them.
- Resolves IEEE special cases without the core.
- For normal/subnormal operands: drives the core's load and iterate enables, counts the 13 radix-4 iterations, then presents the result through an output valid/ready handshake.

Parameters:
- ITERS, 13, number of radix-4 iterations (26-bit partial remainder, 2 bits per step)
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > ITERS

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  controller can accept operands
- dividend  input  32  FP32 dividend
- divisor  input  32  FP32 divisor
- flush  input  1  synchronous abort of the current operation
- core_load  output  1  one-cycle pulse; core latches core_dividend/core_divisor and clears Q_pos/Q_neg
- core_en  output  1  core advances one iteration this cycle
- core_dividend  output  32  registered dividend to the core
- core_divisor  output  32  registered divisor to the core
- core_quotient  input  32  post-processed quotient from the core
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- quotient  output  32  FP32 result, held stable while out_valid=1
- out_special  output  1  result came from the special-case path
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0
  - core_load=0, core_en=0, out_valid=0, out_special=0
  - quotient=0, core_dividend=0, core_divisor=0
  - in_ready=1 once rst=1
- States are IDLE, LOAD, ITER and DONE. Transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, register both operands and classify them via fp32_classify. If special, register the special result, set out_special=1 and go to DONE. Otherwise go to LOAD.
  - LOAD: core_load=1 for exactly one cycle, counter=0, then go to ITER.
  - ITER: core_en=1 every cycle and counter increments. When counter==ITERS-1, core_en is still asserted that cycle, then the state goes to DONE. quotient is captured from core_quotient on the DONE entry edge.
  - DONE: out_valid=1 and quotient is held. On out_ready, go to IDLE and out_valid drops next cycle. in_ready=0 in DONE; there is no same-cycle re-accept.
- Latency, with acceptance at cycle 0:
  - Normal path: out_valid at cycle ITERS+2 (15 at default). Exactly ITERS core_en cycles.
  - Special path: out_valid at cycle 1.
- Special cases, checked in this priority order, with sign s = dividend[31]^divisor[31]:
  - either operand NaN -> 0x7FC00000
  - 0/0 or inf/inf -> 0x7FC00000
  - x/0 (x finite nonzero) or inf/finite -> {s, 0xFF, 23'b0}
  - 0/finite nonzero or finite/inf -> {s, 31'b0}
- Handshakes:
  - in_ready=0 outside IDLE. Operands offered while busy are not consumed.
  - out_valid, once high, stays high with a constant quotient until out_ready is sampled high.
- flush:
  - In LOAD/ITER/DONE, the next state is IDLE. core_en, core_load and out_valid are deasserted next cycle. Any pending result is discarded.
  - In IDLE, flush has priority over acceptance: in_ready is forced to 0 that cycle.
- Reset mid-operation: immediate return to reset values. No result is emitted.
- The counter never wraps within an operation and is cleared in LOAD.

Decomposition:
- Package srt_div_pkg holds:
  - state enum: IDLE, LOAD, ITER, DONE
  - FP32 class enum: ZERO, SUBNORM, NORM, INF, NAN
  - constants FP32_QNAN=32'h7FC00000, FP32_EXP_MAX=8'hFF, SRT4_ITERS=13
- Sub-module fp32_classify: purely combinational. Takes a 32-bit operand and returns its class. Instantiated twice.

Test Plan:
- 6.0/2.0 (0x40C00000/0x40000000), core model returns 0x40400000 -> core_load at cycle 1, core_en high cycles 2–14, out_valid at cycle 15, quotient=0x40400000, out_special=0.
- 1.0/0.0 (0x3F800000/0x00000000) -> out_valid at cycle 1, quotient=0x7F800000, out_special=1, core_load never asserted.
- 0/0, NaN (0x7FC00001)/1.0, and -inf/inf (0xFF800000/0x7F800000) -> quotient=0x7FC00000 each. Then -0.0/5.0 (0x80000000/0x40A00000) -> 0x80000000.
- Normal op with out_ready=0 for 5 cycles after out_valid -> quotient stable, in_ready=0 throughout, new in_valid ignored. One cycle after out_ready=1, state is IDLE.
- flush at the 5th core_en cycle -> core_en=0 next cycle, out_valid never asserted, in_ready=1 next cycle. A following 6.0/2.0 completes with normal latency.
- rst pulsed low during ITER -> all outputs at reset values immediately. After release, core_en count for the next operation is exactly 13.
